// File: rtl/riscv_mdu.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Optional MDU_FAST_MUL_EN: multiplies use a single-cycle 33x33 signed product instead.
module riscv_mdu #(
   parameter int XLEN       = 32,
   parameter int ITER_CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            wb_we,
   output logic [4:0]      wb_rd
);

   // Handshake: start is taken only outside CALC; busy covers the iterations and
   // done is a one-cycle strobe with result/wb_rd stable from that cycle on.
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [ITER_CNT_W-1:0] LAST_CNT = ITER_CNT_W'(XLEN-1);

   state_t                 state_q, state_d;
   logic [2:0]             op_q, op_d;
   logic [4:0]             rd_q, rd_d;
   logic [2*XLEN-1:0]      a_q, a_d;
   logic [XLEN-1:0]        b_q, b_d;
   logic [2*XLEN-1:0]      p_q, p_d;
   logic                   neg_res_q, neg_res_d;
   logic                   neg_rem_q, neg_rem_d;
   logic [ITER_CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]        result_q, result_d;

   logic                   is_div, sgn_a, sgn_b, a_neg, b_neg;
   logic [XLEN-1:0]        a_mag, b_mag;
   logic                   div_zero, div_ovf, special, quick_done;
   logic [XLEN-1:0]        special_res;

   logic [2*XLEN-1:0]      p_mul, a_mul, prod_fin;
   logic [XLEN:0]          rem_sh, rem_new;
   logic [XLEN+1:0]        diff;
   logic                   keep;
   logic [XLEN-1:0]        quo_new, quo_fin, rem_fin, mul_res, calc_res;

   // Operand decode for a new request
   always_comb begin
      is_div   = funct3[2];
      sgn_a    = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                 (funct3 == OP_DIV)  || (funct3 == OP_REM);
      sgn_b    = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
      a_neg    = sgn_a & rs1_val[XLEN-1];
      b_neg    = sgn_b & rs2_val[XLEN-1];
      a_mag    = a_neg ? -rs1_val : rs1_val;
      b_mag    = b_neg ? -rs2_val : rs2_val;
      div_zero = is_div && (rs2_val == '0);
      div_ovf  = is_div && !funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (rs2_val == '1);
      special  = div_zero || div_ovf;
      if (div_zero) begin
         special_res = funct3[1] ? rs1_val : '1;
      end else begin
         special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
   end

`ifdef MDU_FAST_MUL_EN
   logic signed [XLEN:0]     fast_a, fast_b;
   logic signed [2*XLEN-1:0] fast_prod;
   logic [XLEN-1:0]          fast_res;

   // Low 2*XLEN bits of the 33x33 signed product are exact modulo 2^64.
   always_comb begin
      fast_a     = $signed({a_neg, rs1_val});
      fast_b     = $signed({b_neg, rs2_val});
      fast_prod  = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
      fast_res   = (funct3 == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
      quick_done = special || !is_div;
   end
`else
   always_comb begin
      quick_done = special;
   end
`endif

   // One iteration of each algorithm plus the final sign fix-up
   always_comb begin
      p_mul    = b_q[0] ? (p_q + a_q) : p_q;
      a_mul    = a_q << 1;
      rem_sh   = {p_q[XLEN-1:0], a_q[XLEN-1]};
      diff     = {1'b0, rem_sh} - {2'b00, b_q};
      keep     = ~diff[XLEN+1];
      rem_new  = keep ? diff[XLEN:0] : rem_sh;
      quo_new  = {a_q[XLEN-2:0], keep};
      prod_fin = neg_res_q ? -p_mul : p_mul;
      mul_res  = (op_q == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
      quo_fin  = neg_res_q ? -quo_new : quo_new;
      rem_fin  = neg_rem_q ? -rem_new[XLEN-1:0] : rem_new[XLEN-1:0];
      calc_res = op_q[2] ? (op_q[1] ? rem_fin : quo_fin) : mul_res;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         rd_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         p_q       <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         a_q       <= a_d;
         b_q       <= b_d;
         p_q       <= p_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = quick_done ? S_DONE : S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (cnt_q == LAST_CNT) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      op_d      = op_q;
      rd_d      = rd_q;
      a_d       = a_q;
      b_d       = b_q;
      p_d       = p_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      if ((state_q != S_CALC) && start) begin
         op_d      = funct3;
         rd_d      = rd;
         a_d       = {{XLEN{1'b0}}, a_mag};
         b_d       = b_mag;
         p_d       = '0;
         neg_res_d = a_neg ^ b_neg;
         neg_rem_d = a_neg;
         cnt_d     = '0;
         if (special) begin
            result_d = special_res;
         end
`ifdef MDU_FAST_MUL_EN
         else if (!is_div) begin
            result_d = fast_res;
         end
`endif
      end else if (state_q == S_CALC) begin
         cnt_d = cnt_q + 1'b1;
         if (op_q[2]) begin
            a_d = {a_q[2*XLEN-1:XLEN], quo_new};
            p_d = {{(XLEN-1){1'b0}}, rem_new};
         end else begin
            a_d = a_mul;
            b_d = b_q >> 1;
            p_d = p_mul;
         end
         if (cnt_q == LAST_CNT) begin
            result_d = calc_res;
         end
      end
   end

   always_comb begin
      busy   = (state_q == S_CALC);
      done   = (state_q == S_DONE);
      wb_we  = done && (rd_q != 5'd0);
      wb_rd  = rd_q;
      result = result_q;
   end

endmodule
